// File: rtl/fbuf_pkg.sv
// Shared framebuffer definitions: writer FSM states, bank sizing and the
// resolution constants also used by the display timing block.
package fbuf_pkg;

  localparam int FB_W_DEFAULT            = 320;
  localparam int FB_H_DEFAULT            = 240;
  localparam int PIXEL_WIDTH_DEFAULT     = 24;
  localparam int FBUF_ADDR_WIDTH_DEFAULT = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2,
    ST_SWAP  = 2'd3
  } fbuf_state_t;

  function automatic int fbuf_bank_size(input int fb_w, input int fb_h);
    return fb_w * fb_h;
  endfunction

endpackage

// File: rtl/fbuf_addr_gen.sv
// Pixel position tracker for the framebuffer writer: x/y counters with running
// line-base and bank-offset registers, so the write address needs no multiplier.
module fbuf_addr_gen
  import fbuf_pkg::*;
#(
  parameter int FB_W      = FB_W_DEFAULT,
  parameter int FB_H      = FB_H_DEFAULT,
  parameter int AW        = FBUF_ADDR_WIDTH_DEFAULT,
  parameter bit INIT_BANK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          adv_x,
  input  logic          adv_line,
  input  logic          bank_toggle,
  output logic [AW-1:0] addr,
  output logic          x_last,
  output logic          y_last
);

  localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;
  localparam logic [AW-1:0] BANK_SIZE = AW'(fbuf_bank_size(FB_W, FB_H));
  localparam logic [AW-1:0] LINE_STEP = AW'(FB_W);

  logic [XW-1:0] x_q, x_eff;
  logic [YW-1:0] y_q, y_eff;
  logic [AW-1:0] line_base_q, line_base_eff;
  logic [AW-1:0] bank_off_q;

  // A restart beat is pixel (0,0) regardless of where the counters stand.
  always_comb begin
    x_eff         = restart ? '0 : x_q;
    y_eff         = restart ? '0 : y_q;
    line_base_eff = restart ? '0 : line_base_q;
    addr          = bank_off_q + line_base_eff + AW'(x_eff);
    x_last        = (x_eff == XW'(FB_W - 1));
    y_last        = (y_eff == YW'(FB_H - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      bank_off_q  <= INIT_BANK ? BANK_SIZE : '0;
    end else begin
      if (bank_toggle) begin
        bank_off_q <= (bank_off_q == '0) ? BANK_SIZE : '0;
      end
      if (adv_line) begin
        x_q <= '0;
        if (y_last) begin
          y_q         <= '0;
          line_base_q <= '0;
        end else begin
          y_q         <= y_eff + 1'b1;
          line_base_q <= line_base_eff + LINE_STEP;
        end
      end else if (adv_x) begin
        x_q         <= x_eff + 1'b1;
        y_q         <= y_eff;
        line_base_q <= line_base_eff;
      end
    end
  end

endmodule

// File: rtl/axis_to_fbuf.sv
// Writes a video AXI4-Stream into the framebuffer BRAM write port, with an
// optional second bank handed to the display only at the start of vertical blank.
module axis_to_fbuf
  import fbuf_pkg::*;
#(
  parameter int FB_W            = FB_W_DEFAULT,
  parameter int FB_H            = FB_H_DEFAULT,
  parameter int PIXEL_WIDTH     = PIXEL_WIDTH_DEFAULT,
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEFAULT,
  parameter int DOUBLE_BUFFER   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIXEL_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       eof_in,
  output logic                       fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_waddr,
  output logic [PIXEL_WIDTH-1:0]     fbuf_wdata,
  output logic                       rd_bank,
  output logic                       frame_done,
  output logic                       sof_err,
  output logic                       eol_err
);

  localparam bit INIT_BANK = (DOUBLE_BUFFER != 0);

  fbuf_state_t state_q, state_d;
  logic        tready_q;
  logic        wr_bank_q, rd_bank_q;
  logic        eof_prev_q;

  logic        accept, writing;
  logic        restart, adv_x, adv_line, line_end, swap;
  logic        do_write, sof_err_d, eol_err_d, frame_done_d;
  logic [FBUF_ADDR_WIDTH-1:0] addr;
  logic        x_last, y_last;

  // Handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
  // s_axis_tready are both high; tready is registered and never depends on tvalid.
  assign accept        = s_axis_tvalid && tready_q;
  assign s_axis_tready = tready_q;

  fbuf_addr_gen #(
    .FB_W      (FB_W),
    .FB_H      (FB_H),
    .AW        (FBUF_ADDR_WIDTH),
    .INIT_BANK (INIT_BANK)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .adv_x       (adv_x),
    .adv_line    (adv_line),
    .bank_toggle (swap),
    .addr        (addr),
    .x_last      (x_last),
    .y_last      (y_last)
  );

  always_comb begin
    state_d      = state_q;
    restart      = 1'b0;
    writing      = 1'b0;
    adv_x        = 1'b0;
    adv_line     = 1'b0;
    line_end     = 1'b0;
    swap         = 1'b0;
    do_write     = 1'b0;
    sof_err_d    = 1'b0;
    eol_err_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE, ST_DROP: begin
        if (accept) begin
          // Start of frame is resolved first so a beat carrying tuser and tlast
          // is pixel (0,0) and then closes line 0.
          if (s_axis_tuser) begin
            restart   = 1'b1;
            sof_err_d = (state_q != ST_IDLE);
          end
          writing = restart || (state_q == ST_WRITE);
          if (writing) begin
            do_write = 1'b1;
            if (s_axis_tlast) begin
              adv_line  = 1'b1;
              line_end  = 1'b1;
              eol_err_d = !x_last;
              state_d   = ST_WRITE;
            end else if (x_last) begin
              eol_err_d = 1'b1;
              state_d   = ST_DROP;
            end else begin
              adv_x   = 1'b1;
              state_d = ST_WRITE;
            end
          end else if (state_q == ST_DROP && s_axis_tlast) begin
            adv_line = 1'b1;
            line_end = 1'b1;
            state_d  = ST_WRITE;
          end
          if (line_end && y_last) begin
            frame_done_d = 1'b1;
            state_d      = (DOUBLE_BUFFER != 0) ? ST_SWAP : ST_IDLE;
          end
        end
      end
      ST_SWAP: begin
        if (eof_in && !eof_prev_q) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      wr_bank_q  <= INIT_BANK;
      rd_bank_q  <= 1'b0;
      eof_prev_q <= 1'b0;
      fbuf_we    <= 1'b0;
      fbuf_waddr <= '0;
      fbuf_wdata <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      eol_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= (state_d != ST_SWAP);
      eof_prev_q <= eof_in;
      if (swap) begin
        rd_bank_q <= wr_bank_q;
        wr_bank_q <= ~wr_bank_q;
      end
      fbuf_we <= do_write;
      if (do_write) begin
        fbuf_waddr <= addr;
        fbuf_wdata <= s_axis_tdata;
      end
      frame_done <= frame_done_d;
      sof_err    <= sof_err_d;
      eol_err    <= eol_err_d;
    end
  end

  assign rd_bank = rd_bank_q;

endmodule

// File: tb/tb_axis_to_fbuf.sv
// Directed bench for axis_to_fbuf at a 4x2 double-buffered framebuffer.
module tb_axis_to_fbuf;

  localparam int FB_W = 4;
  localparam int FB_H = 2;
  localparam int PW   = 24;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          eof_in = 1'b0;
  logic          fbuf_we;
  logic [AW-1:0] fbuf_waddr;
  logic [PW-1:0] fbuf_wdata;
  logic          rd_bank;
  logic          frame_done;
  logic          sof_err;
  logic          eol_err;

  axis_to_fbuf #(
    .FB_W            (FB_W),
    .FB_H            (FB_H),
    .PIXEL_WIDTH     (PW),
    .FBUF_ADDR_WIDTH (AW),
    .DOUBLE_BUFFER   (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .eof_in        (eof_in),
    .fbuf_we       (fbuf_we),
    .fbuf_waddr    (fbuf_waddr),
    .fbuf_wdata    (fbuf_wdata),
    .rd_bank       (rd_bank),
    .frame_done    (frame_done),
    .sof_err       (sof_err),
    .eol_err       (eol_err)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] data;
    logic          user;
    logic          last;
    logic          we;
    logic [AW-1:0] addr;
    logic          eol;
    logic          sof;
    logic          done;
  } vec_t;

  vec_t vecs[$];
  logic [AW+PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [PW-1:0] d, input logic u, input logic l, input logic we,
                     input int a, input logic eol, input logic sof, input logic done);
    vec_t v;
    v.data = d; v.user = u; v.last = l; v.we = we;
    v.addr = AW'(a); v.eol = eol; v.sof = sof; v.done = done;
    vecs.push_back(v);
  endtask

  // Scoreboard: every BRAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (fbuf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", fbuf_waddr, fbuf_wdata);
      end else begin
        logic [AW+PW-1:0] e;
        e = exp_q.pop_front();
        check("waddr", 32'(fbuf_waddr), 32'(e[AW+PW-1:PW]));
        check("wdata", 32'(fbuf_wdata), 32'(e[PW-1:0]));
      end
    end
  end

  // Drivers
  task automatic wait_ready();
    int n = 0;
    while (s_axis_tready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("tready_wait", 32'(s_axis_tready), 32'd1);
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    wait_ready();
    s_axis_tdata  = v.data;
    s_axis_tuser  = v.user;
    s_axis_tlast  = v.last;
    s_axis_tvalid = 1'b1;
    if (v.we) exp_q.push_back({v.addr, v.data});
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    check($sformatf("we[%0d]", i), 32'(fbuf_we), 32'(v.we));
    check($sformatf("eol_err[%0d]", i), 32'(eol_err), 32'(v.eol));
    check($sformatf("sof_err[%0d]", i), 32'(sof_err), 32'(v.sof));
    check($sformatf("frame_done[%0d]", i), 32'(frame_done), 32'(v.done));
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(fbuf_we), 32'd0);
    check({tag, "_waddr"}, 32'(fbuf_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(fbuf_wdata), 32'd0);
    check({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_sof_err"}, 32'(sof_err), 32'd0);
    check({tag, "_eol_err"}, 32'(eol_err), 32'd0);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    eof_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int s_a, s_b, s_c, s_d, s_e, s_f;

  initial begin
    // A: clean frame into bank 1 (offset 8)
    for (int b = 1; b <= 8; b++)
      add(PW'(b), b == 1, (b == 4) || (b == 8), 1'b1, 8 + b - 1, 1'b0, 1'b0, b == 8);
    s_a = vecs.size();
    // B: partial frame into bank 0, cut by reset
    for (int b = 0; b < 3; b++)
      add(PW'('h11 + b), b == 0, 1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0);
    s_b = vecs.size();
    // C: leading garbage, then a clean frame into bank 1
    for (int b = 0; b < 3; b++)
      add(PW'('h20 + b), 1'b0, b == 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++)
      add(PW'('h31 + b), b == 0, (b == 3) || (b == 7), 1'b1, 8 + b, 1'b0, 1'b0, b == 7);
    s_c = vecs.size();
    // D: early tlast on beat 2 of line 0
    add(24'h000041, 1, 0, 1,  8, 0, 0, 0);
    add(24'h000042, 0, 1, 1,  9, 1, 0, 0);
    add(24'h000043, 0, 0, 1, 12, 0, 0, 0);
    add(24'h000044, 0, 0, 1, 13, 0, 0, 0);
    add(24'h000045, 0, 0, 1, 14, 0, 0, 0);
    add(24'h000046, 0, 1, 1, 15, 0, 0, 1);
    s_d = vecs.size();
    // E: line 0 runs to 6 beats before tlast
    add(24'h000051, 1, 0, 1,  8, 0, 0, 0);
    add(24'h000052, 0, 0, 1,  9, 0, 0, 0);
    add(24'h000053, 0, 0, 1, 10, 0, 0, 0);
    add(24'h000054, 0, 0, 1, 11, 1, 0, 0);
    add(24'h000055, 0, 0, 0,  0, 0, 0, 0);
    add(24'h000056, 0, 1, 0,  0, 0, 0, 0);
    add(24'h000057, 0, 0, 1, 12, 0, 0, 0);
    add(24'h000058, 0, 0, 1, 13, 0, 0, 0);
    add(24'h000059, 0, 0, 1, 14, 0, 0, 0);
    add(24'h00005a, 0, 1, 1, 15, 0, 0, 1);
    s_e = vecs.size();
    // F: tuser on beat 5 restarts the frame in the same bank
    add(24'h000061, 1, 0, 1,  8, 0, 0, 0);
    add(24'h000062, 0, 0, 1,  9, 0, 0, 0);
    add(24'h000063, 0, 0, 1, 10, 0, 0, 0);
    add(24'h000064, 0, 1, 1, 11, 0, 0, 0);
    add(24'h000065, 1, 0, 1,  8, 0, 1, 0);
    add(24'h000066, 0, 0, 1,  9, 0, 0, 0);
    add(24'h000067, 0, 0, 1, 10, 0, 0, 0);
    add(24'h000068, 0, 1, 1, 11, 0, 0, 0);
    add(24'h000069, 0, 0, 1, 12, 0, 0, 0);
    add(24'h00006a, 0, 0, 1, 13, 0, 0, 0);
    add(24'h00006b, 0, 0, 1, 14, 0, 0, 0);
    add(24'h00006c, 0, 1, 1, 15, 0, 0, 1);
    s_f = vecs.size();

    // Reset values, then tready rising one cycle after release
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    check("tready_release", 32'(s_axis_tready), 32'd0);
    @(posedge clk); #1;
    check("tready_after_release", 32'(s_axis_tready), 32'd1);

    // Clean frame with vblank already active: swap waits for a fresh rising edge
    eof_in = 1'b1;
    apply_range(0, s_a);
    check("swap_tready_entry", 32'(s_axis_tready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("swap_hold_tready", 32'(s_axis_tready), 32'd0);
      check("swap_hold_rd_bank", 32'(rd_bank), 32'd0);
    end
    eof_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 eof_in = 1'b1;
    @(posedge clk); #1;
    check("swap_rd_bank", 32'(rd_bank), 32'd1);
    check("swap_tready", 32'(s_axis_tready), 32'd1);
    eof_in = 1'b0;

    // Partial frame into bank 0, then reset mid-frame
    apply_range(s_a, s_b);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    @(posedge clk); #1;

    apply_range(s_b, s_c);
    do_reset();
    apply_range(s_c, s_d);
    do_reset();
    apply_range(s_d, s_e);
    do_reset();
    apply_range(s_e, s_f);
    check("post_frame_tready", 32'(s_axis_tready), 32'd0);
    do_reset();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
